// File: rtl/rom_burst_arbiter_pkg.sv
// Shared FSM encodings, requester ids and read-tag layout for the ROM burst arbiter.
package rom_burst_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Travels with each ROM read until its data reaches the response registers.
    typedef struct packed {
        logic vld;
        logic owner;
        logic last;
    } tag_t;

endpackage

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the requester not granted last.
// Latency: combinational grant while en is high. Backpressure: none, requests simply wait for en.
module rr_arb2
    import rom_burst_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (ptr_q == REQ1) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
        if (gnt[0]) begin
            ptr_d = REQ1;
        end else if (gnt[1]) begin
            ptr_d = REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one registered-output ROM between two burst requesters, round-robin per burst.
// Latency: grant and first read in the request cycle; each word returns two cycles after issue.
// Backpressure: a request waits until no burst is issuing; responses cannot be stalled.
module rom_burst_arbiter
    import rom_burst_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] len0,
    output logic                  gnt0,
    output logic                  vld0,
    output logic [DATA_WIDTH-1:0] do0,
    output logic                  last0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] len1,
    output logic                  gnt1,
    output logic                  vld1,
    output logic [DATA_WIDTH-1:0] do1,
    output logic                  last1,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_a,
    input  logic [DATA_WIDTH-1:0] rom_do,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    tag_t                  tag_q, tag_d;
    logic                  vld0_q, vld0_d, vld1_q, vld1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [DATA_WIDTH-1:0] do0_q, do0_d, do1_q, do1_d;

    logic [1:0]            arb_gnt;
    logic                  arb_en;
    logic                  issue_vld;
    logic                  issue_last;
    logic                  issue_owner;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // Gating with rst_n keeps grants and ROM enables dead while reset is held.
    assign arb_en = rst_n && (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1, req0}),
        .en    (arb_en),
        .gnt   (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        issue_vld   = 1'b0;
        issue_last  = 1'b0;
        issue_owner = owner_q;
        issue_addr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    issue_vld   = 1'b1;
                    issue_owner = arb_gnt[1] ? REQ1 : REQ0;
                    issue_addr  = arb_gnt[1] ? addr1 : addr0;
                    cnt_d       = arb_gnt[1] ? len1 : len0;
                    addr_d      = issue_addr + ONE;
                    owner_d     = issue_owner;
                    issue_last  = (cnt_d == '0);
                    state_d     = issue_last ? ST_IDLE : ST_BURST;
                end
            end
            ST_BURST: begin
                // Dropping to IDLE on the final issue lets the next grant land with no bubble.
                issue_vld  = 1'b1;
                issue_addr = addr_q;
                addr_d     = addr_q + ONE;
                cnt_d      = cnt_q - ONE;
                issue_last = (cnt_q == ONE);
                if (issue_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tag_d.vld   = issue_vld;
        tag_d.owner = issue_owner;
        tag_d.last  = issue_last;

        vld0_d  = tag_q.vld && (tag_q.owner == REQ0);
        vld1_d  = tag_q.vld && (tag_q.owner == REQ1);
        last0_d = vld0_d && tag_q.last;
        last1_d = vld1_d && tag_q.last;
        do0_d   = vld0_d ? rom_do : do0_q;
        do1_d   = vld1_d ? rom_do : do1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            owner_q <= REQ0;
            tag_q   <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            do0_q   <= '0;
            do1_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            tag_q   <= tag_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            do0_q   <= do0_d;
            do1_q   <= do1_d;
        end
    end

    assign gnt0   = arb_gnt[0];
    assign gnt1   = arb_gnt[1];
    assign rom_en = issue_vld;
    assign rom_a  = issue_addr;
    assign vld0   = vld0_q;
    assign vld1   = vld1_q;
    assign last0  = last0_q;
    assign last1  = last1_q;
    assign do0    = do0_q;
    assign do1    = do1_q;
    assign busy   = issue_vld || tag_q.vld || vld0_q || vld1_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter: ROM model returns 16'h1111 * address,
// returned words are checked against a queue of expected words filled when requests are driven.
module tb_rom_burst_arbiter;

    typedef struct packed {
        logic        owner;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [3:0]  addr0, addr1, len0, len1;
    logic        gnt0, gnt1, vld0, vld1, last0, last1;
    logic [15:0] do0, do1;
    logic        rom_en;
    logic [3:0]  rom_a;
    logic [15:0] rom_do;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_do0, exp_do1;

    rom_burst_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .addr0  (addr0),
        .len0   (len0),
        .gnt0   (gnt0),
        .vld0   (vld0),
        .do0    (do0),
        .last0  (last0),
        .req1   (req1),
        .addr1  (addr1),
        .len1   (len1),
        .gnt1   (gnt1),
        .vld1   (vld1),
        .do1    (do1),
        .last1  (last1),
        .rom_en (rom_en),
        .rom_a  (rom_a),
        .rom_do (rom_do),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [3:0] a);
        return 16'(32'h1111 * 32'(a));
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_do <= rom_word(rom_a);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic who, input logic r, input logic [3:0] a, input logic [3:0] l);
        if (who) begin
            req1 = r; addr1 = a; len1 = l;
        end else begin
            req0 = r; addr0 = a; len0 = l;
        end
    endtask

    task automatic push_burst(input logic who, input logic [3:0] a, input logic [3:0] l);
        exp_t e;
        for (int k = 0; k <= int'(l); k++) begin
            e.owner = who;
            e.data  = rom_word(4'(a + 4'(k)));
            e.last  = (k == int'(l));
            sb.push_back(e);
        end
    endtask

    // Each returned word is popped and compared; doN of both ports must match the last word seen per owner.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_do0 = '0;
            exp_do1 = '0;
        end else if (vld0 || vld1) begin
            if (sb.size() == 0) begin
                chk("unexpected_vld", 32'({vld1, vld0}), 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.owner) exp_do1 = mon_e.data;
                else             exp_do0 = mon_e.data;
                chk("vld_owner", 32'({vld1, vld0}), mon_e.owner ? 2 : 1);
                chk("do0", 32'(do0), 32'(exp_do0));
                chk("do1", 32'(do1), 32'(exp_do1));
                chk("last", 32'({last1, last0}), 32'({mon_e.owner & mon_e.last, ~mon_e.owner & mon_e.last}));
            end
        end
    end

    // Single-requester burst: grant in the drive cycle, then one consecutive address per cycle.
    task automatic burst(input logic who, input logic [3:0] a, input logic [3:0] l);
        set_req(who, 1'b1, a, l);
        push_burst(who, a, l);
        #1;
        chk("burst_gnt", 32'({gnt1, gnt0}), who ? 2 : 1);
        chk("burst_rom_a0", 32'({busy, rom_en, rom_a}), 32'({2'b11, a}));
        @(posedge clk); #1;
        set_req(who, 1'b0, a, l);
        for (int k = 1; k <= int'(l); k++) begin
            @(negedge clk); #1;
            chk("burst_issue", 32'({busy, rom_en, rom_a, gnt1, gnt0}), 32'({2'b11, 4'(a + 4'(k)), 2'b00}));
        end
    endtask

    // Both requesters with len=1: first granted at T, second at T+2, rom_en never drops.
    task automatic contend(input logic first, input logic [3:0] af, input logic [3:0] as);
        set_req(first, 1'b1, af, 4'd1);
        set_req(~first, 1'b1, as, 4'd1);
        push_burst(first, af, 4'd1);
        push_burst(~first, as, 4'd1);
        #1;
        chk("contend_gnt_first", 32'({gnt1, gnt0, rom_en, rom_a}), 32'({first, ~first, 1'b1, af}));
        @(posedge clk); #1;
        set_req(first, 1'b0, af, 4'd1);
        @(negedge clk); #1;
        chk("contend_issue1", 32'({gnt1, gnt0, rom_en, rom_a}), 32'({2'b00, 1'b1, 4'(af + 4'd1)}));
        @(negedge clk); #1;
        chk("contend_gnt_second", 32'({gnt1, gnt0, rom_en, rom_a}), 32'({~first, first, 1'b1, as}));
        @(posedge clk); #1;
        set_req(~first, 1'b0, as, 4'd1);
        @(negedge clk); #1;
        chk("contend_issue3", 32'({gnt1, gnt0, rom_en, rom_a}), 32'({2'b00, 1'b1, 4'(as + 4'd1)}));
    endtask

    // Counts remaining busy cycles (bounded) and requires every expected word to have returned.
    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!busy) break;
            n++;
        end
        chk(tag, n, exp_n);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 1'b1, 4'd6, 4'd1);
        set_req(1'b1, 1'b1, 4'd9, 4'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", 32'({gnt1, gnt0, vld1, vld0, last1, last0, rom_en, busy}), 0);
        chk("rst_rom_a", 32'(rom_a), 0);
        chk("rst_do", 32'({do1, do0}), 0);

        // Contention straight out of reset, then again after requester 1 was last.
        @(negedge clk);
        rst_n = 1'b1;
        contend(1'b0, 4'd6, 4'd9);
        drain("contend_tail", 2);
        contend(1'b0, 4'd4, 4'd12);
        drain("contend2_tail", 2);

        burst(1'b0, 4'd2, 4'd2);
        drain("single_tail", 2);

        // Requester 0 was last, so requester 1 now wins the tie.
        contend(1'b1, 4'd13, 4'd0);
        drain("contend3_tail", 2);

        burst(1'b1, 4'd14, 4'd3);
        drain("wrap_tail", 2);

        burst(1'b0, 4'd5, 4'd15);
        drain("full_busy_tail", 2);

        // Requester 1 pulses for one cycle mid-burst: no grant may result.
        set_req(1'b0, 1'b1, 4'd8, 4'd4);
        push_burst(1'b0, 4'd8, 4'd4);
        #1;
        chk("wd_gnt0", 32'({gnt1, gnt0}), 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 4'd8, 4'd4);
        set_req(1'b1, 1'b1, 4'd3, 4'd0);
        @(negedge clk); #1;
        chk("wd_no_gnt1", 32'({gnt1, gnt0}), 0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 4'd3, 4'd0);
        drain("wd_tail", 5);

        // Reset two cycles into a len=7 burst; the pointer favours 1 beforehand.
        set_req(1'b0, 1'b1, 4'd3, 4'd7);
        push_burst(1'b0, 4'd3, 4'd7);
        #1;
        chk("rst_mid_gnt0", 32'({gnt1, gnt0}), 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 4'd3, 4'd7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({gnt1, gnt0, vld1, vld0, last1, last0, rom_en, busy}), 0);
        chk("rst_mid_rom_a", 32'(rom_a), 0);
        chk("rst_mid_do", 32'({do1, do0}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_quiet", 32'({busy, vld1, vld0}), 0);
        contend(1'b0, 4'd1, 4'd7);
        drain("post_rst_contend_tail", 2);
        burst(1'b1, 4'd11, 4'd0);
        drain("post_rst_req1_tail", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
